// File: rtl/var_delay_line_pkg.sv
// Shared definitions for the variable delay line: FSM encodings,
// a constant clog2 helper and the default depth.
package var_delay_line_pkg;

    // Fill-tracking states; the state always agrees with cnt and delay_q.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_DELAY = 16;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/var_delay_line_ring_buffer.sv
// Circular sample store: one write port advancing a wrap-explicit pointer,
// and a combinational read at a fixed offset behind the write pointer.
// Contents are never cleared; only the pointer is reset.
module ring_buffer
    import var_delay_line_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = DEFAULT_MAX_DELAY,
    parameter int OW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [W-1:0]  wdata,
    input  logic [OW-1:0] offset,
    output logic [W-1:0]  rdata
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int SW = ((AW > OW) ? AW : OW) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] wp_x;
    logic [SW-1:0] off_x;

    // Write pointer advances per accepted sample; wrap is explicit so any depth works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
        end else if (we) begin
            wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
        end
    end

    // Storage write; deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[wp] <= wdata;
    end

    // Read address = (wp - offset) mod DEPTH; offset == DEPTH lands on wp (oldest sample).
    always_comb begin
        wp_x  = SW'(wp);
        off_x = SW'(offset);
        if (wp_x >= off_x) rd_addr = AW'(wp_x - off_x);
        else               rd_addr = AW'(wp_x + SW'(DEPTH) - off_x);
    end

    assign rdata = mem[rd_addr];

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel delay line with run-time selectable delay. Built on a
// ring buffer; tracks fill level so ovalid marks samples delayed by exactly
// D, restarts tracking on flush or on any change of the clamped delay.
// Handshake: ce=1 on a rising edge means one sample on idata is accepted;
// there is no back-pressure. ovalid=1 means odata is a genuine sample
// delayed by delay_q accepted samples (or idata itself when delay_q=0).
module var_delay_line
    import var_delay_line_pkg::*;
#(
    parameter int N         = 8,
    parameter int CH        = 1,
    parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
    localparam int DW       = clog2(MAX_DELAY + 1),
    localparam int AW       = (MAX_DELAY > 1) ? clog2(MAX_DELAY) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            flush,
    input  logic [DW-1:0]   delay,
    input  logic [CH*N-1:0] idata,
    output logic [CH*N-1:0] odata,
    output logic            ovalid,
    output logic            full
);

    localparam logic [DW-1:0] MAXD = DW'(MAX_DELAY);

    logic [DW-1:0]   delay_c;
    logic [DW-1:0]   delay_q;
    logic [DW-1:0]   cnt;
    logic [DW-1:0]   cnt_next;
    logic            restart;
    logic [CH*N-1:0] rd_data;
    state_t          state;
    state_t          state_next;

    ring_buffer #(
        .W     (CH * N),
        .DEPTH (MAX_DELAY),
        .OW    (DW)
    ) u_ring (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (ce),
        .wdata  (idata),
        .offset (delay_q),
        .rdata  (rd_data)
    );

    // Clamp the request and detect restart (flush or changed delay, regardless of ce).
    always_comb begin
        delay_c = (delay > MAXD) ? MAXD : delay;
        restart = flush | (delay_c != delay_q);
    end

    // Fill counter: restart wins but still counts a coincident sample; saturates at MAX_DELAY.
    always_comb begin
        cnt_next = cnt;
        if (restart) begin
            cnt_next = ce ? DW'(1) : '0;
        end else if (ce && (cnt != MAXD)) begin
            cnt_next = cnt + DW'(1);
        end
    end

    // Next state follows the counter against the delay adopted on this edge.
    always_comb begin
        state_next = state;
        if (delay_c == '0)              state_next = ST_RUN;
        else if (cnt_next == '0)        state_next = ST_EMPTY;
        else if (cnt_next >= delay_c)   state_next = ST_RUN;
        else                            state_next = ST_FILL;
    end

    // FSM state register; EMPTY in reset keeps ovalid low even with delay_q=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    // Delay and fill-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= '0;
            cnt     <= '0;
        end else begin
            delay_q <= delay_c;
            cnt     <= cnt_next;
        end
    end

    // Output gating: zero unless valid; D=0 passes idata straight through.
    always_comb begin
        ovalid = (state == ST_RUN);
        full   = (cnt == MAXD);
        odata  = '0;
        if (ovalid) odata = (delay_q == '0) ? idata : rd_data;
    end

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line (N=8, CH=2, MAX_DELAY=16).
module tb_var_delay_line;

    localparam int N  = 8;
    localparam int CH = 2;
    localparam int MD = 16;
    localparam int DW = 5;

    logic            clk;
    logic            rst_n;
    logic            ce;
    logic            flush;
    logic [DW-1:0]   delay;
    logic [CH*N-1:0] idata;
    logic [CH*N-1:0] odata;
    logic            ovalid;
    logic            full;

    int checks;
    int errors;

    var_delay_line #(.N(N), .CH(CH), .MAX_DELAY(MD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .flush  (flush),
        .delay  (delay),
        .idata  (idata),
        .odata  (odata),
        .ovalid (ovalid),
        .full   (full)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel 1 carries channel 0 + 0x80 so the two lanes are distinguishable.
    function automatic logic [15:0] pk(input logic [7:0] v);
        logic [7:0] hi;
        hi = v + 8'h80;
        return {hi, v};
    endfunction

    // Driver: apply inputs, clock one edge, settle 1 ns past it.
    task automatic step(input logic c, input logic f, input logic [DW-1:0] d,
                        input logic [15:0] din);
        ce    = c;
        flush = f;
        delay = d;
        idata = din;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce    = 1'b0;
        flush = 1'b0;
        delay = '0;
        idata = pk(8'h11);
        #1;
        checks++; if (odata !== 16'h0)   begin errors++; $display("FAIL reset_odata got %h exp %h", odata, 16'h0); end
        checks++; if (ovalid !== 1'b0)   begin errors++; $display("FAIL reset_ovalid got %b exp 0", ovalid); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        #12;
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        step(1'b1, 1'b0, 5'd0, pk(8'h21));
        checks++; if (ovalid !== 1'b1)       begin errors++; $display("FAIL pass_ovalid got %b exp 1", ovalid); end
        checks++; if (odata !== pk(8'h21))   begin errors++; $display("FAIL pass_odata got %h exp %h", odata, pk(8'h21)); end
        idata = pk(8'h33);
        #1;
        checks++; if (odata !== pk(8'h33))   begin errors++; $display("FAIL pass_comb got %h exp %h", odata, pk(8'h33)); end
    endtask

    task automatic test_fill_d5();
        logic [15:0] exp_d;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 5'd5, pk(8'(k)));
            exp_d = (k >= 5) ? pk(8'(k - 4)) : 16'h0;
            checks++; if (ovalid !== (k >= 5)) begin errors++; $display("FAIL d5_ovalid k=%0d got %b exp %b", k, ovalid, (k >= 5)); end
            checks++; if (odata !== exp_d)     begin errors++; $display("FAIL d5_odata k=%0d got %h exp %h", k, odata, exp_d); end
        end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL d5_full got %b exp 0", full); end
    endtask

    task automatic test_delay_change();
        logic [15:0] exp_d;
        for (int j = 0; j < 5; j++) begin
            step(1'b1, 1'b0, 5'd3, pk(8'(13 + j)));
            exp_d = (j >= 2) ? pk(8'(11 + j)) : 16'h0;
            checks++; if (ovalid !== (j >= 2)) begin errors++; $display("FAIL chg_ovalid j=%0d got %b exp %b", j, ovalid, (j >= 2)); end
            checks++; if (odata !== exp_d)     begin errors++; $display("FAIL chg_odata j=%0d got %h exp %h", j, odata, exp_d); end
        end
    endtask

    task automatic test_ce_gating();
        logic        pat [6];
        logic [7:0]  v;
        logic [7:0]  last;
        logic [15:0] exp_d;
        pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        v    = 8'd18;
        last = 8'd17;
        for (int i = 0; i < 6; i++) begin
            if (pat[i]) begin
                step(1'b1, 1'b0, 5'd3, pk(v));
                last = v;
                v    = v + 8'd1;
            end else begin
                step(1'b0, 1'b0, 5'd3, 16'hEEEE);
            end
            exp_d = pk(last - 8'd2);
            checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL ce_ovalid i=%0d got %b exp 1", i, ovalid); end
            checks++; if (odata !== exp_d) begin errors++; $display("FAIL ce_odata i=%0d got %h exp %h", i, odata, exp_d); end
        end
    endtask

    task automatic test_flush();
        logic [15:0] exp_d;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 5'd4, pk(8'(40 + k)));
        checks++; if (odata !== pk(8'd44)) begin errors++; $display("FAIL fl_run got %h exp %h", odata, pk(8'd44)); end
        for (int j = 0; j < 4; j++) begin
            step(1'b1, (j == 0), 5'd4, pk(8'(48 + j)));
            exp_d = (j == 3) ? pk(8'd48) : 16'h0;
            checks++; if (ovalid !== (j == 3)) begin errors++; $display("FAIL fl_ovalid j=%0d got %b exp %b", j, ovalid, (j == 3)); end
            checks++; if (odata !== exp_d)     begin errors++; $display("FAIL fl_odata j=%0d got %h exp %h", j, odata, exp_d); end
        end
        // flush together with a delay change: one restart, new delay adopted
        step(1'b1, 1'b1, 5'd2, pk(8'd52));
        checks++; if (ovalid !== 1'b0)     begin errors++; $display("FAIL flchg_ovalid0 got %b exp 0", ovalid); end
        step(1'b1, 1'b0, 5'd2, pk(8'd53));
        checks++; if (ovalid !== 1'b1)     begin errors++; $display("FAIL flchg_ovalid1 got %b exp 1", ovalid); end
        checks++; if (odata !== pk(8'd52)) begin errors++; $display("FAIL flchg_odata got %h exp %h", odata, pk(8'd52)); end
    endtask

    task automatic test_clamp();
        logic [15:0] exp_d;
        for (int k = 0; k <= 16; k++) begin
            step(1'b1, 1'b0, 5'd20, pk(8'(60 + k)));
            exp_d = (k >= 15) ? pk(8'(45 + k)) : 16'h0;
            checks++; if (ovalid !== (k >= 15)) begin errors++; $display("FAIL clamp_ovalid k=%0d got %b exp %b", k, ovalid, (k >= 15)); end
            checks++; if (odata !== exp_d)      begin errors++; $display("FAIL clamp_odata k=%0d got %h exp %h", k, odata, exp_d); end
            checks++; if (full !== (k >= 15))   begin errors++; $display("FAIL clamp_full k=%0d got %b exp %b", k, full, (k >= 15)); end
        end
        // same clamped value requested explicitly: no restart
        step(1'b1, 1'b0, 5'd16, pk(8'd77));
        checks++; if (ovalid !== 1'b1)     begin errors++; $display("FAIL clamp_same_ovalid got %b exp 1", ovalid); end
        checks++; if (odata !== pk(8'd62)) begin errors++; $display("FAIL clamp_same_odata got %h exp %h", odata, pk(8'd62)); end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] exp_d;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 5'd6, {8'hA5, 8'(80 + k)});
        checks++; if (odata !== {8'hA5, 8'd82}) begin errors++; $display("FAIL ch2_run got %h exp %h", odata, {8'hA5, 8'd82}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (odata !== 16'h0) begin errors++; $display("FAIL midrst_odata got %h exp 0000", odata); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL midrst_ovalid got %b exp 0", ovalid); end
        checks++; if (full !== 1'b0)   begin errors++; $display("FAIL midrst_full got %b exp 0", full); end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0, 5'd6, {8'hA5, 8'(90 + k)});
            exp_d = (k >= 5) ? {8'hA5, 8'(85 + k)} : 16'h0;
            checks++; if (ovalid !== (k >= 5)) begin errors++; $display("FAIL ch2_ovalid k=%0d got %b exp %b", k, ovalid, (k >= 5)); end
            checks++; if (odata !== exp_d)     begin errors++; $display("FAIL ch2_odata k=%0d got %h exp %h", k, odata, exp_d); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_passthrough();
        test_fill_d5();
        test_delay_change();
        test_ce_gating();
        test_flush();
        test_clamp();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
